z16_program_writer: RTL
=======================

# z16_program_writer

Inverse of the Z16 instruction decoder. It accepts decoded instruction fields (opcode, rd, rs1, rs2, immediate) over a valid/ready stream and packs each into a 16-bit Z16 instruction word. It range-checks the immediate, then writes the word into instruction memory at consecutive byte addresses. It sits between the test/boot loader front end and the instruction memory write port.

## Interface
Parameters:
- `MAX_WORDS`, default 256: words accepted per session before the block reports full. Range 1..32768.

Ports:
- `i_clk` input 1: clock; all state changes on the rising edge.
- `i_rst` input 1: asynchronous, active-high reset.
- `i_start` input 1: opens a session. Honoured only in IDLE.
- `i_base_addr` input 16: first byte address of the session. Sampled with `i_start`; bit 0 is forced to 0.
- `i_finish` input 1: closes the session. Honoured in RUN and FULL.
- `i_valid` input 1: field tuple valid.
- `o_ready` output 1: block can accept a tuple this cycle.
- `i_opcode` input 4: opcode.
- `i_rd_addr` input 4: rd field.
- `i_rs1_addr` input 4: rs1 field.
- `i_rs2_addr` input 4: rs2 field.
- `i_imm` input 16: sign-extended immediate value.
- `o_mem_wen` output 1: one-cycle instruction-memory write strobe.
- `o_mem_addr` output 16: write byte address.
- `o_mem_wdata` output 16: encoded instruction word.
- `o_busy` output 1: high in RUN or FULL.
- `o_full` output 1: high in FULL.
- `o_done` output 1: one-cycle pulse on return to IDLE via `i_finish`.
- `o_count` output 16: words written in the current or last session.
- `o_err_imm` output 1: sticky; an immediate was out of range this session.
- `o_err_count` output 8: rejected tuples this session; saturates at 255.

## Operation
- Encoding is the exact inverse of the decoder. Field positions: opcode [3:0], rd [7:4], rs1 [11:8], rs2 [15:12].
  - Opcode 9: [15:8] = imm[7:0], [7:4] = rd. Legal imm range -128..127, i.e. imm[15:7] all equal.
  - Opcode A: [15:12] = imm[3:0], [11:8] = rs1, [7:4] = rd. Legal imm range -8..7, i.e. imm[15:3] all equal.
  - Opcode B: [15:12] = rs2, [11:8] = rs1, [7:4] = imm[3:0]. Legal imm range -8..7. `i_rd_addr` is ignored.
  - All other opcodes: register layout rd/rs1/rs2. `i_imm` is ignored and never errors.
- FSM states: IDLE, RUN, FULL.
  - IDLE → RUN on `i_start`. This loads the address with `{i_base_addr[15:1],1'b0}` and clears `o_count`, `o_err_imm` and `o_err_count`.
  - RUN → FULL when an accepted write makes `o_count == MAX_WORDS`.
  - RUN/FULL → IDLE on `i_finish`, with an `o_done` pulse. `o_count` is held after the session ends.
- `o_ready` = (state == RUN). A tuple is accepted on any edge where `i_valid && o_ready`.
- Legal tuple: encoded and written, then the address advances by 2 (modulo 2^16; 0xFFFE wraps to 0x0000) and `o_count` increments by 1.
- Illegal immediate: the tuple is consumed with no write. The address and `o_count` are unchanged, `o_err_imm` sets and `o_err_count` increments.
- An accepted tuple in the same cycle as `i_finish`: the tuple is processed and written, then the FSM goes to IDLE.
- `i_start` outside IDLE is ignored.
- An illegal tuple never causes the transition to FULL.

## Timing
- Write latency is 1 cycle: a tuple accepted at edge N produces `o_mem_wen`=1 with registered addr/wdata during the cycle after edge N.
- `o_mem_wen` is high for exactly 1 cycle per legal tuple. Sustained throughput is 1 word per cycle.
- `o_ready` falls in the cycle after the accept that fills the block, so no tuple is accepted in FULL.
- `o_done` is high for the 1 cycle after the `i_finish` edge. A final write strobe may coincide with it.
- Reset values: state IDLE, and all outputs 0 (`o_ready`, `o_mem_wen`, `o_mem_addr`, `o_mem_wdata`, `o_busy`, `o_full`, `o_done`, `o_count`, `o_err_imm`, `o_err_count`).
- Reset asserted mid-session returns to IDLE immediately. Any pending write strobe is dropped.

## Structure
- Shared package `z16_pkg` holds:
  - opcode constants `OP_LI8`=4'h9, `OP_ALUI4`=4'hA, `OP_STORE`=4'hB;
  - field bit-position localparams;
  - the immediate-width constants (8 and 4).

  The decoder and this block both import it.
- Sub-module `z16_instr_pack` is purely combinational. It takes the fields and returns `{word, imm_ok}`. The top module holds the FSM, counters and output registers.

## Test plan
- Opcode 9, rd=3, imm=0xFFF0 (-16), base 0x0100 → one write with addr 0x0100, data 0xF039, `o_count`=1.
- Opcode A, rd=2, rs1=5, imm=7, then opcode B, rs1=4, rs2=6, imm=0xFFFF, back-to-back → data 0x752A @ base, then 0x64FB @ base+2, in consecutive cycles.
- Opcode 0, rd=1, rs1=2, rs2=3, imm=0x1234 → data 0x3210, no error.
- Opcode A with imm=8, then opcode 9 with imm=0x0080 → no writes, `o_err_imm`=1, `o_err_count`=2, address and `o_count` unchanged.
- `MAX_WORDS`=4, base 0xFFFC, 5 valid beats → writes at 0xFFFC, 0xFFFE, 0x0000, 0x0002, then `o_full`=1, `o_ready`=0, 5th beat not accepted. `i_finish` → `o_done` pulse, `o_count`=4.
- Assert `i_rst` mid-session one cycle after an accept → no `o_mem_wen`, all outputs 0, state IDLE. A subsequent `i_start` works normally.

Source files
------------

// File: rtl/z16_pkg.sv
// Shared Z16 encoding constants, field layout and stream payload types.
// Imported by both the instruction decoder and the program writer.
package z16_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned OPC_W   = 4;
    localparam int unsigned REG_W   = 4;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned ERRC_W  = 8;

    localparam int unsigned OPC_LSB     = 0;
    localparam int unsigned RD_LSB      = 4;
    localparam int unsigned RS1_LSB     = 8;
    localparam int unsigned RS2_LSB     = 12;
    localparam int unsigned IMM8_LSB    = 8;
    localparam int unsigned IMM4_HI_LSB = 12;
    localparam int unsigned IMM4_LO_LSB = 4;

    localparam int unsigned IMM8_W = 8;
    localparam int unsigned IMM4_W = 4;

    localparam logic [OPC_W-1:0] OP_LI8   = 4'h9;
    localparam logic [OPC_W-1:0] OP_ALUI4 = 4'hA;
    localparam logic [OPC_W-1:0] OP_STORE = 4'hB;

    typedef struct packed {
        logic [OPC_W-1:0] opcode;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
    } z16_fields_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FULL = 2'd2
    } wr_state_t;

    // True when imm is the sign extension of its low 'width' bits.
    function automatic logic imm_fits(input logic [IMM_W-1:0] imm, input int unsigned width);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < IMM_W; i++) begin
            if ((i >= width - 1) && (imm[i[3:0]] != imm[IMM_W-1])) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/z16_instr_pack.sv
// Combinational packer: decoded Z16 fields -> 16-bit instruction word,
// plus a flag saying whether the immediate fits the opcode's field.
module z16_instr_pack
    import z16_pkg::*;
(
    input  z16_fields_t        i_fields,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_imm_ok
);

    always_comb begin
        o_word   = '0;
        o_imm_ok = 1'b1;
        o_word[OPC_LSB +: OPC_W] = i_fields.opcode;
        case (i_fields.opcode)
            OP_LI8: begin
                o_word[IMM8_LSB +: IMM8_W] = i_fields.imm[IMM8_W-1:0];
                o_word[RD_LSB   +: REG_W]  = i_fields.rd;
                o_imm_ok = imm_fits(i_fields.imm, IMM8_W);
            end
            OP_ALUI4: begin
                o_word[IMM4_HI_LSB +: IMM4_W] = i_fields.imm[IMM4_W-1:0];
                o_word[RS1_LSB     +: REG_W]  = i_fields.rs1;
                o_word[RD_LSB      +: REG_W]  = i_fields.rd;
                o_imm_ok = imm_fits(i_fields.imm, IMM4_W);
            end
            OP_STORE: begin
                o_word[RS2_LSB     +: REG_W]  = i_fields.rs2;
                o_word[RS1_LSB     +: REG_W]  = i_fields.rs1;
                o_word[IMM4_LO_LSB +: IMM4_W] = i_fields.imm[IMM4_W-1:0];
                o_imm_ok = imm_fits(i_fields.imm, IMM4_W);
            end
            default: begin
                o_word[RS2_LSB +: REG_W] = i_fields.rs2;
                o_word[RS1_LSB +: REG_W] = i_fields.rs1;
                o_word[RD_LSB  +: REG_W] = i_fields.rd;
            end
        endcase
    end

endmodule

// File: rtl/z16_program_writer.sv
// Packs decoded instruction tuples into Z16 words and streams them into
// instruction memory at consecutive byte addresses, one session at a time.
module z16_program_writer
    import z16_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256
)(
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic                i_finish,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [OPC_W-1:0]    i_opcode,
    input  logic [REG_W-1:0]    i_rd_addr,
    input  logic [REG_W-1:0]    i_rs1_addr,
    input  logic [REG_W-1:0]    i_rs2_addr,
    input  logic [IMM_W-1:0]    i_imm,
    output logic                o_mem_wen,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [INSTR_W-1:0]  o_mem_wdata,
    output logic                o_busy,
    output logic                o_full,
    output logic                o_done,
    output logic [CNT_W-1:0]    o_count,
    output logic                o_err_imm,
    output logic [ERRC_W-1:0]   o_err_count
);

    localparam logic [CNT_W-1:0]  COUNT_MAX = CNT_W'(MAX_WORDS);
    localparam logic [ERRC_W-1:0] ERRC_SAT  = '1;

    wr_state_t           r_state,       w_state_nxt;
    logic [ADDR_W-1:0]   r_addr,        w_addr_nxt;
    logic [CNT_W-1:0]    r_count,       w_count_nxt;
    logic                r_err_imm,     w_err_imm_nxt;
    logic [ERRC_W-1:0]   r_err_count,   w_err_count_nxt;
    logic                r_mem_wen,     w_mem_wen_nxt;
    logic [ADDR_W-1:0]   r_mem_addr,    w_mem_addr_nxt;
    logic [INSTR_W-1:0]  r_mem_wdata,   w_mem_wdata_nxt;
    logic                r_done,        w_done_nxt;
    logic                r_ready;
    logic                r_busy;
    logic                r_full;

    z16_fields_t         w_fields;
    logic [INSTR_W-1:0]  w_word;
    logic                w_imm_ok;
    logic                w_accept;
    logic [CNT_W-1:0]    w_count_inc;

    assign w_fields = '{opcode: i_opcode, rd: i_rd_addr, rs1: i_rs1_addr,
                        rs2: i_rs2_addr, imm: i_imm};

    z16_instr_pack u_pack (
        .i_fields (w_fields),
        .o_word   (w_word),
        .o_imm_ok (w_imm_ok)
    );

    assign w_accept    = i_valid && (r_state == ST_RUN);
    assign w_count_inc = r_count + CNT_W'(1);

    // Next-state and next-output logic for every register.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_count_nxt     = r_count;
        w_err_imm_nxt   = r_err_imm;
        w_err_count_nxt = r_err_count;
        w_mem_wen_nxt   = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_done_nxt      = 1'b0;

        case (r_state)
            ST_RUN, ST_FULL: begin
                if (w_accept) begin
                    if (w_imm_ok) begin
                        w_mem_wen_nxt   = 1'b1;
                        w_mem_addr_nxt  = r_addr;
                        w_mem_wdata_nxt = w_word;
                        w_addr_nxt      = r_addr + ADDR_W'(2);
                        w_count_nxt     = w_count_inc;
                    end else begin
                        w_err_imm_nxt = 1'b1;
                        if (r_err_count != ERRC_SAT) begin
                            w_err_count_nxt = r_err_count + ERRC_W'(1);
                        end
                    end
                end
                // A finish wins over filling up; the tuple above is still written.
                if (i_finish) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_accept && w_imm_ok && (w_count_inc == COUNT_MAX)) begin
                    w_state_nxt = ST_FULL;
                end
            end
            default: begin
                if (i_start) begin
                    w_state_nxt     = ST_RUN;
                    w_addr_nxt      = i_base_addr & ADDR_W'(16'hFFFE);
                    w_count_nxt     = '0;
                    w_err_imm_nxt   = 1'b0;
                    w_err_count_nxt = '0;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_count     <= '0;
            r_err_imm   <= 1'b0;
            r_err_count <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_full      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_count     <= w_count_nxt;
            r_err_imm   <= w_err_imm_nxt;
            r_err_count <= w_err_count_nxt;
            r_mem_wen   <= w_mem_wen_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_done      <= w_done_nxt;
            r_ready     <= (w_state_nxt == ST_RUN);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_full      <= (w_state_nxt == ST_FULL);
        end
    end

    assign o_ready     = r_ready;
    assign o_busy      = r_busy;
    assign o_full      = r_full;
    assign o_done      = r_done;
    assign o_mem_wen   = r_mem_wen;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_count     = r_count;
    assign o_err_imm   = r_err_imm;
    assign o_err_count = r_err_count;

endmodule
